// File: rtl/m68k_bus_if.sv
// 68000 bus signals between the CPU and the glue-logic decoder.
interface m68k_bus_if;
   logic        as_n;
   logic        uds_n;
   logic        lds_n;
   logic        rw;
   logic [10:0] addr;
   logic        dtack_n;
   logic        berr_n;

   modport master (output as_n, uds_n, lds_n, rw, addr, input dtack_n, berr_n);
   modport slave  (input as_n, uds_n, lds_n, rw, addr, output dtack_n, berr_n);
endinterface

// File: rtl/m68k_decoder.sv
// 68000 address decode, chip selects and DTACK/BERR generation.
// addr carries A23..A13; bus-cycle timing runs on clk50 from a synchronized as_n.
module m68k_decoder (
   input  logic             clk50,
   input  logic             reset_n,
   input  logic             clk16,
   output logic             clk_from_cpld,
   m68k_bus_if.slave        bus,
   input  logic             boot,
   input  logic             dtack_trig,
   output logic             oe_n,
   output logic             ram_ce_n,
   output logic             eeprom_uds_n,
   output logic             eeprom_lds_n,
   output logic [3:0]       cs
);

   typedef enum logic [1:0] {
      REG_NONE   = 2'd0,
      REG_RAM    = 2'd1,
      REG_EEPROM = 2'd2,
      REG_IO     = 2'd3
   } region_t;

   logic       eeprom_sel;
   logic       ram_sel;
   logic       io_sel;
   region_t    region;
   region_t    region_q;

   logic       as_s1, as_sync;
   logic       trig_s1, trig_sync;
   logic [7:0] cnt;
   logic       dtack_q, berr_q;
   logic       dtack_nxt, berr_nxt;

   assign clk_from_cpld = clk16;

   // Boot overlay maps the EEPROM at 0 and hides the RAM there.
   assign eeprom_sel = (bus.addr[10:6] == 5'b11110) || (boot && (bus.addr[10:6] == 5'b00000));
   assign ram_sel    = !boot && (bus.addr[10:7] == 4'b0000);
   assign io_sel     = (bus.addr[10:2] == 9'b111111110);

   always_comb begin
      region = REG_NONE;
      if (eeprom_sel)
         region = REG_EEPROM;
      else if (ram_sel)
         region = REG_RAM;
      else if (io_sel)
         region = REG_IO;
   end

   assign ram_ce_n     = !(!bus.as_n && ram_sel);
   assign eeprom_uds_n = !(!bus.as_n && !bus.uds_n && eeprom_sel);
   assign eeprom_lds_n = !(!bus.as_n && !bus.lds_n && eeprom_sel);
   assign oe_n         = !(!bus.as_n && bus.rw);
   assign cs           = (!bus.as_n && io_sel) ? (4'b0001 << bus.addr[1:0]) : 4'b0000;

   // Responses are registered one edge ahead, so the compare uses count-1.
   always_comb begin
      dtack_nxt = dtack_q;
      berr_nxt  = berr_q;
      if (as_sync) begin
         dtack_nxt = 1'b1;
         berr_nxt  = 1'b1;
      end else if (dtack_q && berr_q && (cnt != 8'd0)) begin
         if ((cnt == 8'd254) || ((region_q == REG_NONE) && (cnt == 8'd1)))
            berr_nxt = 1'b0;
         else if (((region_q == REG_RAM)    && (cnt == 8'd1)) ||
                  ((region_q == REG_EEPROM) && (cnt == 8'd3)) ||
                  ((region_q == REG_IO)     && trig_sync))
            dtack_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         as_s1     <= 1'b1;
         as_sync   <= 1'b1;
         trig_s1   <= 1'b0;
         trig_sync <= 1'b0;
         cnt       <= 8'd0;
         region_q  <= REG_NONE;
         dtack_q   <= 1'b1;
         berr_q    <= 1'b1;
      end else begin
         as_s1     <= bus.as_n;
         as_sync   <= as_s1;
         trig_s1   <= dtack_trig;
         trig_sync <= trig_s1;
         if (as_sync)
            cnt <= 8'd0;
         else if (cnt != 8'hFF)
            cnt <= cnt + 8'd1;
         if (!as_sync && (cnt == 8'd0))
            region_q <= region;
         dtack_q <= dtack_nxt;
         berr_q  <= berr_nxt;
      end
   end

   assign bus.dtack_n = dtack_q;
   assign bus.berr_n  = berr_q;

endmodule

// File: tb/tb_m68k_decoder.sv
// Bench for m68k_decoder: decode vector table plus timed bus-cycle sequences.
module tb_m68k_decoder;

   logic       clk50 = 1'b0;
   logic       clk16 = 1'b0;
   logic       reset_n = 1'b0;
   logic       boot = 1'b0;
   logic       dtack_trig = 1'b0;
   logic       clk_from_cpld, oe_n, ram_ce_n, eeprom_uds_n, eeprom_lds_n;
   logic [3:0] cs;

   m68k_bus_if bus();

   m68k_decoder dut (
      .clk50        (clk50),
      .reset_n      (reset_n),
      .clk16        (clk16),
      .clk_from_cpld(clk_from_cpld),
      .bus          (bus),
      .boot         (boot),
      .dtack_trig   (dtack_trig),
      .oe_n         (oe_n),
      .ram_ce_n     (ram_ce_n),
      .eeprom_uds_n (eeprom_uds_n),
      .eeprom_lds_n (eeprom_lds_n),
      .cs           (cs)
   );

   always #10 clk50 = ~clk50;
   always #31 clk16 = ~clk16;

   typedef struct {
      logic        boot, as_n, uds_n, lds_n, rw;
      logic [10:0] addr;
      logic        oe_n, ram_ce_n, eu_n, el_n;
      logic [3:0]  cs;
   } vec_t;

   typedef struct {
      int   edges;
      logic berr;
   } resp_t;

   vec_t  vecs[$];
   vec_t  vec_q[$];
   resp_t resp_q[$];
   int    n_checks = 0;
   int    n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic start_cycle(input logic b, input logic [10:0] a, input logic u,
                              input logic l, input logic r);
      @(negedge clk50);
      boot     = b;
      bus.addr = a;
      bus.uds_n = u;
      bus.lds_n = l;
      bus.rw   = r;
      bus.as_n = 1'b0;
   endtask

   task automatic wait_resp(input int limit, output int edges);
      edges = 0;
      do begin
         @(posedge clk50);
         #1;
         edges++;
      end while (bus.dtack_n === 1'b1 && bus.berr_n === 1'b1 && edges < limit);
   endtask

   task automatic check_resp(input string nm, input int edges);
      resp_t e;
      e = resp_q.pop_front();
      check({nm, "_edges"}, edges, e.edges);
      check({nm, "_berr_n"}, bus.berr_n, !e.berr);
      check({nm, "_dtack_n"}, bus.dtack_n, e.berr);
   endtask

   task automatic end_cycle(input string nm);
      @(negedge clk50);
      bus.as_n = 1'b1;
      #1;
      check({nm, "_cs_idle"}, cs, 4'b0000);
      repeat (3) @(posedge clk50);
      #1;
      check({nm, "_dtack_release"}, bus.dtack_n, 1'b1);
      check({nm, "_berr_release"}, bus.berr_n, 1'b1);
   endtask

   task automatic run_cycle(input string nm, input logic b, input logic [10:0] a,
                            input logic u, input logic l, input logic r,
                            input int exp_edges, input logic exp_berr);
      int e;
      resp_q.push_back('{exp_edges, exp_berr});
      start_cycle(b, a, u, l, r);
      wait_resp(400, e);
      check_resp(nm, e);
   endtask

   initial begin
      int   e;
      vec_t v;

      bus.as_n  = 1'b1;
      bus.uds_n = 1'b1;
      bus.lds_n = 1'b1;
      bus.rw    = 1'b1;
      bus.addr  = 11'h000;

      // boot as_n uds lds rw addr | oe ram eu el cs
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 11'h000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h780, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h7BF, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'h7F9, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'h7F8, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'h7FA, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'h7FB, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h7FB, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h7FC, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h400, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h07F, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h080, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h03F, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h040, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000});

      // Reset state, held across clock edges
      repeat (3) @(posedge clk50);
      #1;
      check("reset_dtack_n", bus.dtack_n, 1'b1);
      check("reset_berr_n", bus.berr_n, 1'b1);
      @(negedge clk50);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk50);
         boot      = vecs[i].boot;
         bus.as_n  = vecs[i].as_n;
         bus.uds_n = vecs[i].uds_n;
         bus.lds_n = vecs[i].lds_n;
         bus.rw    = vecs[i].rw;
         bus.addr  = vecs[i].addr;
         vec_q.push_back(vecs[i]);
         #2;
         v = vec_q.pop_front();
         check($sformatf("vec%0d_oe_n", i), oe_n, v.oe_n);
         check($sformatf("vec%0d_ram_ce_n", i), ram_ce_n, v.ram_ce_n);
         check($sformatf("vec%0d_eeprom_uds_n", i), eeprom_uds_n, v.eu_n);
         check($sformatf("vec%0d_eeprom_lds_n", i), eeprom_lds_n, v.el_n);
         check($sformatf("vec%0d_cs", i), cs, v.cs);
         check($sformatf("vec%0d_clk_from_cpld", i), clk_from_cpld, clk16);
      end
      @(negedge clk50);
      bus.as_n = 1'b1;
      repeat (4) @(posedge clk50);

      run_cycle("ram", 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 4, 1'b0);
      end_cycle("ram");
      run_cycle("eeprom_boot", 1'b1, 11'h000, 1'b1, 1'b0, 1'b1, 6, 1'b0);
      check("eeprom_boot_lds", eeprom_lds_n, 1'b0);
      check("eeprom_boot_uds", eeprom_uds_n, 1'b1);
      check("eeprom_boot_ram", ram_ce_n, 1'b1);
      end_cycle("eeprom_boot");
      run_cycle("eeprom_hi", 1'b0, 11'h780, 1'b0, 1'b0, 1'b1, 6, 1'b0);
      end_cycle("eeprom_hi");
      run_cycle("unmapped", 1'b0, 11'h400, 1'b0, 1'b0, 1'b1, 4, 1'b1);
      check("unmapped_cs", cs, 4'b0000);
      check("unmapped_ram", ram_ce_n, 1'b1);
      check("unmapped_eeprom", {eeprom_uds_n, eeprom_lds_n}, 2'b11);
      end_cycle("unmapped");

      // I/O: no response until the peripheral raises dtack_trig
      resp_q.push_back('{3, 1'b0});
      start_cycle(1'b0, 11'h7F9, 1'b0, 1'b0, 1'b1);
      repeat (10) @(posedge clk50);
      #1;
      check("io_wait_dtack_n", bus.dtack_n, 1'b1);
      check("io_cs", cs, 4'b0010);
      @(negedge clk50);
      dtack_trig = 1'b1;
      wait_resp(20, e);
      check_resp("io_trig", e);
      end_cycle("io_trig");
      dtack_trig = 1'b0;
      repeat (3) @(posedge clk50);

      run_cycle("io_timeout", 1'b0, 11'h7F8, 1'b0, 1'b0, 1'b1, 257, 1'b1);
      end_cycle("io_timeout");

      // Address moves to unmapped space after the decode is latched
      resp_q.push_back('{6, 1'b0});
      start_cycle(1'b0, 11'h780, 1'b0, 1'b0, 1'b1);
      repeat (3) @(posedge clk50);
      @(negedge clk50);
      bus.addr = 11'h400;
      wait_resp(20, e);
      check_resp("latched_decode", e + 3);
      end_cycle("latched_decode");

      // Reset while DTACK is held, then restart with as_n still low
      run_cycle("rst_ram", 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 4, 1'b0);
      @(negedge clk50);
      reset_n = 1'b0;
      #1;
      check("rst_async_dtack_n", bus.dtack_n, 1'b1);
      check("rst_async_berr_n", bus.berr_n, 1'b1);
      check("rst_comb_ram_ce_n", ram_ce_n, 1'b0);
      check("rst_comb_oe_n", oe_n, 1'b0);
      @(negedge clk50);
      reset_n = 1'b1;
      resp_q.push_back('{4, 1'b0});
      wait_resp(20, e);
      check_resp("rst_restart", e);
      end_cycle("rst_restart");

      run_cycle("rst_berr", 1'b0, 11'h400, 1'b0, 1'b0, 1'b1, 4, 1'b1);
      @(negedge clk50);
      reset_n = 1'b0;
      #1;
      check("rst_berr_async_berr_n", bus.berr_n, 1'b1);
      check("rst_berr_async_dtack_n", bus.dtack_n, 1'b1);
      @(negedge clk50);
      reset_n = 1'b1;
      end_cycle("rst_berr");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/m68k_decoder.md
M68K_DECODER -- requirements
Module: m68k_decoder

Interface
REQ-001 SHALL have ports: clk50 in 1 (sole clock; all sequential logic on rising edge); reset_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have ports: clk16 in 1 (16 MHz oscillator, not a logic clock); clk_from_cpld out 1 (CPU clock).
REQ-003 SHALL have CPU bus inputs: as_n in 1; uds_n in 1; lds_n in 1; rw in 1 (1=read); addr in 11 (A23..A13).
REQ-004 SHALL have control inputs: boot in 1 (1=boot overlay active); dtack_trig in 1 (peripheral ready, active-high).
REQ-005 SHALL have CPU outputs: dtack_n out 1; berr_n out 1.
REQ-006 SHALL have memory outputs: oe_n out 1; ram_ce_n out 1; eeprom_uds_n out 1; eeprom_lds_n out 1.
REQ-007 SHALL have peripheral output cs out 4 (one-hot, active-high I/O selects).

Function
REQ-008 SHALL drive clk_from_cpld = clk16 combinationally (buffer only).
REQ-009 SHALL decode addr combinationally: EEPROM when A23..A19=11110 (0xF00000-0xF7FFFF), or when boot=1 and A23..A19=00000.
REQ-010 SHALL decode RAM when boot=0 and A23..A20=0000 (0x000000-0x0FFFFF).
REQ-011 SHALL decode I/O when A23..A15=111111110 (0xFF0000-0xFF7FFF); cs[A14:A13]=1 while as_n=0, all other cs bits 0.
REQ-012 SHALL treat any other address as unmapped.
REQ-013 SHALL drive ram_ce_n = 0 only while as_n=0 and RAM selected.
REQ-014 SHALL drive eeprom_uds_n = 0 only while as_n=0, uds_n=0 and EEPROM selected; eeprom_lds_n likewise with lds_n.
REQ-015 SHALL drive oe_n = 0 only while as_n=0 and rw=1, independent of decode.
REQ-016 SHALL synchronize as_n and dtack_trig through two clk50 flip-flops before use in sequential logic.
REQ-017 SHALL count clk50 cycles in an 8-bit counter from the first cycle synchronized as_n is low; counter holds 0 while synchronized as_n is high.
REQ-018 SHALL assert dtack_n=0 (registered) at count 2 for RAM and at count 4 for EEPROM.
REQ-019 SHALL assert dtack_n=0 for I/O on the clk50 edge after synchronized dtack_trig=1.
REQ-020 SHALL assert berr_n=0 (registered) at count 2 for unmapped addresses.
REQ-021 SHALL assert berr_n=0 at count 255 if dtack_n is still 1 (timeout), for any region.
REQ-022 SHALL never assert dtack_n and berr_n in the same cycle; berr takes priority.
REQ-023 SHALL hold dtack_n/berr_n asserted until synchronized as_n is high, then deassert both on that same edge.
REQ-024 SHALL latch the decode result at count 0; address changes mid-cycle do not alter the dtack/berr decision.

Reset
REQ-025 SHALL, while reset_n=0, force dtack_n=1, berr_n=1, counter=0 and synchronizer flops to idle (as_n=1, dtack_trig=0), independent of clk50.
REQ-026 SHALL keep combinational outputs (ram_ce_n, eeprom_*_n, oe_n, cs, clk_from_cpld) functional during reset.
REQ-027 SHALL, on reset deassertion mid-bus-cycle, restart counting from 0 at the next synchronized as_n low.

Verification
REQ-028 boot=0, addr=0x000 (0x000000), rw=1, as_n/uds_n/lds_n=0 -> ram_ce_n=0, oe_n=0, dtack_n=0 4 clk50 edges after as_n falls (2 sync + 2).
REQ-029 boot=1, addr=0x000, lds_n=0, uds_n=1 -> ram_ce_n=1, eeprom_lds_n=0, eeprom_uds_n=1, dtack_n=0 after 6 edges.
REQ-030 addr=0x7F9 (0xFF2000), as_n=0 -> cs=4'b0010; dtack_n stays 1 until dtack_trig=1, then 0 three edges later; as_n=1 -> dtack_n=1, cs=0.
REQ-031 addr=0x400 (0x800000), as_n=0 -> berr_n=0 after 4 edges, dtack_n stays 1, all chip selects inactive.
REQ-032 I/O access with dtack_trig held 0 -> berr_n=0 at count 255; reset_n=0 mid-cycle -> dtack_n=1, berr_n=1 immediately.
